parity_frame_checker: RTL and testbench
=======================================

# parity_frame_checker

- Serial receiver and parity checker downstream of the parity generator.
- Deserialises a frame of `DATA_W` message bits followed by one parity bit.
- Recomputes even or odd parity over the message and presents the parallel message with a one-cycle valid pulse and an error flag.
- Accumulates a saturating count of bad frames.

## Interface
Parameters
- `DATA_W`, 3: message width in bits (>= 1); matches the generator's message width.
- `ODD_PARITY`, 0: 0 = even parity check, 1 = odd parity check.
- `CNT_W`, 8: width of the error counter.

Ports
- `clk`  input  1  single clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `bit_in`  input  1  serial frame bit; message bits LSB first, parity bit last.
- `bit_valid`  input  1  `bit_in` is sampled only on cycles with `bit_valid` = 1.
- `frame_start`  input  1  qualifies the current valid bit as message bit 0.
- `data_out`  output  `DATA_W`  last received message, held until the next frame completes.
- `data_valid`  output  1  one-cycle pulse when `data_out`/`parity_err` update.
- `parity_err`  output  1  1 = parity of the last frame mismatched; held with `data_out`.
- `busy`  output  1  1 while a frame is in progress (state RECV or PAR).
- `err_count`  output  `CNT_W`  saturating count of frames with `parity_err` = 1.

## Operation
- Reset (`rst_n` = 0 at a clock edge):
  - state = IDLE; shift register and bit index = 0.
  - `data_out` = 0, `data_valid` = 0, `parity_err` = 0, `busy` = 0, `err_count` = 0.
  - Reset overrides all other inputs.
- States:
  - IDLE: a valid bit without `frame_start` is ignored. `bit_valid` & `frame_start` captures `bit_in` as bit 0. Next state is RECV, or PAR when `DATA_W` = 1.
  - RECV: each valid bit is stored at index 1..`DATA_W`-1. After the bit at index `DATA_W`-1 is stored, next state is PAR.
  - PAR: the next valid bit is the received parity `p`.
    - expected = XOR of message bits, inverted when `ODD_PARITY` = 1.
    - Update `data_out` = message, `parity_err` = (`p` != expected), pulse `data_valid`.
    - Return to IDLE.
- Cycles with `bit_valid` = 0 are gaps. State, index and shift register hold. Gaps of any length are allowed at any point in a frame.
- Resync: `bit_valid` & `frame_start` in RECV or PAR aborts the current frame.
  - No output is produced for the aborted frame.
  - The current bit becomes bit 0 of a new frame.
- `frame_start` without `bit_valid` has no effect in any state.
- `err_count` increments by 1 on each `data_valid` pulse with `parity_err` = 1. It saturates at 2^`CNT_W`-1 and does not wrap.
- Arithmetic: parity is a pure XOR reduction over exactly `DATA_W` bits. The bit index is `clog2(DATA_W)` bits wide (minimum 1).

## Timing
- All outputs are registered.
- `data_valid` asserts in the cycle after the edge that samples the parity bit, for exactly one cycle. Latency from parity bit to result is 1 cycle.
- Back-to-back frames:
  - A new frame's bit 0 (with `frame_start`) may arrive in the cycle immediately after the parity bit.
  - The state machine is back in IDLE by then, so no bubble is needed.
- `busy` rises the cycle after bit 0 is sampled. It falls in the same cycle `data_valid` rises.
- `err_count` reflects a new error in the same cycle as the corresponding `data_valid` pulse.
- Reset asserted mid-frame discards the partial frame. No `data_valid` is produced for it.

## Configuration
- Macro `PARITY_ERR_COUNT_EN`.
  - Defined: `err_count` behaves as described above.
  - Undefined: the counter logic is removed and `err_count` is tied to 0.
- `data_out`, `data_valid` and `parity_err` are identical in both builds.

## Test plan
- Even, `DATA_W` = 3: `frame_start` with bits 1,0,1 then parity 0 -> `data_valid` pulse one cycle later; `data_out` = 3'b101, `parity_err` = 0, `err_count` = 0.
- Even: bits 0,1,1 (message 3'b110) with parity 1 -> `data_out` = 3'b110, `parity_err` = 1, `err_count` = 1. Repeat with `ODD_PARITY` = 1 and parity 1 -> `parity_err` = 0.
- Gaps and ignored bits:
  - Valid bits without `frame_start` while IDLE produce no output.
  - A frame 1,1,1,1 with 3-cycle gaps between bits gives `data_out` = 3'b111, `parity_err` = 0 (even).
- Resync and reset:
  - After bits 1,0, a new `frame_start` with bits 0,0,1 and parity 1 gives a single pulse with `data_out` = 3'b100, `parity_err` = 0.
  - `rst_n` = 0 after 2 bits gives no pulse, and all outputs are 0 the next cycle.
- Saturation, `CNT_W` = 2, macro defined: 5 bad frames back-to-back, with no idle cycles, give `err_count` = 1,2,3,3,3 and five `data_valid` pulses.
- Saturation, macro undefined: the same stimulus gives `err_count` = 0 throughout.

Source files
------------

// File: rtl/parity_frame_checker.sv
// -----------------------------------------------------------------------------
// parity_frame_checker
//
// Serial receiver and parity checker. A frame is DATA_W message bits, sent
// LSB first, followed by one parity bit. The receiver rebuilds the message,
// recomputes even or odd parity and presents the result with a one-cycle
// valid pulse and an error flag.
//
// Optional feature macro: PARITY_ERR_COUNT_EN
//   defined   : err_count is a saturating count of frames with a parity error
//   undefined : counter logic is removed and err_count is tied to 0
//
// Parameters
//   DATA_W     message width in bits (>= 1)
//   ODD_PARITY 0 = even parity check, 1 = odd parity check
//   CNT_W      width of the error counter
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   bit_in       serial frame bit (message LSB first, parity bit last)
//   bit_valid    bit_in is sampled only when this is 1
//   frame_start  marks the current valid bit as message bit 0
//   data_out     last received message, held until the next frame completes
//   data_valid   one-cycle pulse when data_out / parity_err update
//   parity_err   1 = parity of the last frame mismatched
//   busy         1 while a frame is in progress
//   err_count    saturating count of frames with parity_err = 1
// -----------------------------------------------------------------------------
module parity_frame_checker #(
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  // Bit index is clog2(DATA_W) bits wide, but never narrower than one bit.
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic ODD_SEL = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              busy_q;

  // Combinational helpers for the parity-bit cycle.
  logic exp_par_d;     // parity bit the sender should have produced
  logic par_err_d;     // received parity bit disagrees with exp_par_d
  logic frame_done_d;  // this edge samples the parity bit of a live frame

  always_comb begin
    exp_par_d    = (^shift_q) ^ ODD_SEL;
    par_err_d    = bit_in ^ exp_par_d;
    // A frame_start on the parity slot is a resync, not a parity bit.
    frame_done_d = bit_valid && !frame_start && (state_q == PAR);
  end

  // ---------------------------------------------------------------------------
  // Receive FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;

      if (bit_valid) begin
        if (frame_start) begin
          // Start (or restart) a frame from any state; a partial frame in
          // progress is silently dropped.
          shift_q <= DATA_W'(bit_in);
          busy_q  <= 1'b1;
          if (DATA_W == 1) begin
            state_q <= PAR;
            idx_q   <= '0;
          end else begin
            state_q <= RECV;
            idx_q   <= IDX_W'(1);
          end
        end else begin
          case (state_q)
            IDLE: begin
              // Stray valid bits outside a frame are ignored.
            end

            RECV: begin
              shift_q[idx_q] <= bit_in;
              if (idx_q == LAST_IDX) begin
                state_q <= PAR;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end

            PAR: begin
              data_out_q   <= shift_q;
              parity_err_q <= par_err_d;
              data_valid_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
              idx_q        <= '0;
            end

            default: begin
              state_q <= IDLE;
              idx_q   <= '0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;

  // ---------------------------------------------------------------------------
  // Saturating bad-frame counter
  // ---------------------------------------------------------------------------
`ifdef PARITY_ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  // Updates on the same edge that raises data_valid, so the count already
  // includes the new error while the pulse is visible.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_done_d && par_err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  // Counter removed; frame_done_d only feeds the counter.
  logic unused_frame_done;
  assign unused_frame_done = frame_done_d;
  assign err_count         = '0;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_checker
//
// Directed bench for parity_frame_checker. Four instances share one stimulus
// bus: even DATA_W=3 (main), odd DATA_W=3, even DATA_W=3 with CNT_W=2
// (saturation), and even DATA_W=1. Expected counter values follow the
// PARITY_ERR_COUNT_EN macro of the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parity_frame_checker;

`ifdef PARITY_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic frame_start = 1'b0;

  logic [2:0] dout_e, dout_o, dout_s;
  logic [0:0] dout_1;
  logic       dv_e, dv_o, dv_s, dv_1;
  logic       err_e, err_o, err_s, err_1;
  logic       busy_e, busy_o, busy_s, busy_1;
  logic [7:0] cnt_e, cnt_o, cnt_1;
  logic [1:0] cnt_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(3), .ODD_PARITY(0), .CNT_W(8)) u_e (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_e), .data_valid(dv_e),
    .parity_err(err_e), .busy(busy_e), .err_count(cnt_e));

  parity_frame_checker #(.DATA_W(3), .ODD_PARITY(1), .CNT_W(8)) u_o (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_o), .data_valid(dv_o),
    .parity_err(err_o), .busy(busy_o), .err_count(cnt_o));

  parity_frame_checker #(.DATA_W(3), .ODD_PARITY(0), .CNT_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_s), .data_valid(dv_s),
    .parity_err(err_s), .busy(busy_s), .err_count(cnt_s));

  parity_frame_checker #(.DATA_W(1), .ODD_PARITY(0), .CNT_W(8)) u_1 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_1), .data_valid(dv_1),
    .parity_err(err_1), .busy(busy_1), .err_count(cnt_1));

  // One valid bit; returns 1 ns after the sampling edge.
  task automatic send(input logic b, input logic fs);
    bit_in      = b;
    bit_valid   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Gap cycles; frame_start may be held high to show it is ignored.
  task automatic gap(input int n, input logic fs);
    bit_valid   = 1'b0;
    frame_start = fs;
    bit_in      = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bit_valid = 1'b1; frame_start = 1'b1; bit_in = 1'b1;  // reset must win
    repeat (2) @(posedge clk);
    #1;
    bit_valid = 1'b0; frame_start = 1'b0;
    total++; if (dout_e !== 3'b000) $display("FAIL reset_data_out: got %b expected 000", dout_e); else passed++;
    total++; if (dv_e !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", dv_e); else passed++;
    total++; if (err_e !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", err_e); else passed++;
    total++; if (busy_e !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_e); else passed++;
    total++; if (cnt_e !== 8'd0) $display("FAIL reset_err_count: got %0d expected 0", cnt_e); else passed++;
    rst_n = 1'b1;
    $display("reset: data_out=%b valid=%b err=%b busy=%b cnt=%0d", dout_e, dv_e, err_e, busy_e, cnt_e);
  endtask

  task automatic test_even_good();
    send(1'b1, 1'b1);
    total++; if (busy_e !== 1'b1) $display("FAIL good_busy_rise: got %b expected 1", busy_e); else passed++;
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    total++; if (dv_e !== 1'b0) $display("FAIL good_no_early_pulse: got %b expected 0", dv_e); else passed++;
    send(1'b0, 1'b0);  // parity
    total++; if (dv_e !== 1'b1) $display("FAIL good_valid: got %b expected 1", dv_e); else passed++;
    total++; if (dout_e !== 3'b101) $display("FAIL good_data: got %b expected 101", dout_e); else passed++;
    total++; if (err_e !== 1'b0) $display("FAIL good_err: got %b expected 0", err_e); else passed++;
    total++; if (busy_e !== 1'b0) $display("FAIL good_busy_fall: got %b expected 0", busy_e); else passed++;
    total++; if (cnt_e !== 8'd0) $display("FAIL good_cnt: got %0d expected 0", cnt_e); else passed++;
    total++; if (err_o !== 1'b1) $display("FAIL good_odd_err: got %b expected 1", err_o); else passed++;
    $display("frame even 101 p=0: data_out=%b err=%b cnt=%0d | odd err=%b", dout_e, err_e, cnt_e, err_o);
    gap(1, 1'b0);
    total++; if (dv_e !== 1'b0) $display("FAIL good_pulse_width: got %b expected 0", dv_e); else passed++;
    total++; if (dout_e !== 3'b101) $display("FAIL good_data_hold: got %b expected 101", dout_e); else passed++;
  endtask

  task automatic test_even_bad();
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);  // parity
    total++; if (dv_e !== 1'b1) $display("FAIL bad_valid: got %b expected 1", dv_e); else passed++;
    total++; if (dout_e !== 3'b110) $display("FAIL bad_data: got %b expected 110", dout_e); else passed++;
    total++; if (err_e !== 1'b1) $display("FAIL bad_err: got %b expected 1", err_e); else passed++;
    total++; if (cnt_e !== (CNT_EN ? 8'd1 : 8'd0)) $display("FAIL bad_cnt: got %0d expected %0d", cnt_e, CNT_EN ? 1 : 0); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL bad_odd_err: got %b expected 0", err_o); else passed++;
    total++; if (dout_o !== 3'b110) $display("FAIL bad_odd_data: got %b expected 110", dout_o); else passed++;
    $display("frame even 110 p=1: data_out=%b err=%b cnt=%0d | odd err=%b", dout_e, err_e, cnt_e, err_o);
    gap(1, 1'b0);
  endtask

  task automatic test_ignored();
    for (int i = 0; i < 3; i++) begin
      send(1'(i & 1), 1'b0);
      total++; if (dv_e !== 1'b0 || busy_e !== 1'b0) $display("FAIL ignored_bit%0d: valid=%b busy=%b expected 0 0", i, dv_e, busy_e); else passed++;
    end
    $display("ignored bits: data_out=%b held", dout_e);
  endtask

  task automatic test_gaps();
    int pulses = 0;
    send(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      // frame_start without bit_valid during gaps must not restart the frame
      for (int g = 0; g < 3; g++) begin
        gap(1, 1'b1);
        if (dv_e === 1'b1) pulses++;
      end
      send(1'b1, 1'b0);
      if (i < 2 && dv_e === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL gaps_early_pulse: got %0d pulses expected 0", pulses); else passed++;
    total++; if (dv_e !== 1'b1) $display("FAIL gaps_valid: got %b expected 1", dv_e); else passed++;
    total++; if (dout_e !== 3'b111) $display("FAIL gaps_data: got %b expected 111", dout_e); else passed++;
    total++; if (err_e !== 1'b0) $display("FAIL gaps_err: got %b expected 0", err_e); else passed++;
    $display("frame gapped 111 p=1: data_out=%b err=%b", dout_e, err_e);
    gap(1, 1'b0);
  endtask

  task automatic test_resync();
    int pulses = 0;
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);  // resync
    if (dv_e === 1'b1) pulses++;
    send(1'b0, 1'b0);
    if (dv_e === 1'b1) pulses++;
    send(1'b1, 1'b0);
    if (dv_e === 1'b1) pulses++;
    send(1'b1, 1'b0);  // parity
    if (dv_e === 1'b1) pulses++;
    gap(2, 1'b0);
    if (dv_e === 1'b1) pulses++;
    total++; if (pulses !== 1) $display("FAIL resync_pulses: got %0d expected 1", pulses); else passed++;
    total++; if (dout_e !== 3'b100) $display("FAIL resync_data: got %b expected 100", dout_e); else passed++;
    total++; if (err_e !== 1'b0) $display("FAIL resync_err: got %b expected 0", err_e); else passed++;
    $display("frame resync 100 p=1: data_out=%b err=%b pulses=%0d", dout_e, err_e, pulses);
  endtask

  task automatic test_reset_mid();
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    do_reset();
    total++; if (dout_e !== 3'b000) $display("FAIL rstmid_data: got %b expected 000", dout_e); else passed++;
    total++; if (dv_e !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", dv_e); else passed++;
    total++; if (err_e !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", err_e); else passed++;
    total++; if (busy_e !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_e); else passed++;
    total++; if (cnt_e !== 8'd0) $display("FAIL rstmid_cnt: got %0d expected 0", cnt_e); else passed++;
    // Remaining bits of the discarded frame must not complete it.
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    total++; if (dv_e !== 1'b0 || busy_e !== 1'b0) $display("FAIL rstmid_tail: valid=%b busy=%b expected 0 0", dv_e, busy_e); else passed++;
    $display("reset mid-frame: data_out=%b valid=%b busy=%b", dout_e, dv_e, busy_e);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_s;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(1'b0, 1'b1);
      total++; if (busy_s !== 1'b1) $display("FAIL b2b_busy_%0d: got %b expected 1", k, busy_s); else passed++;
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);  // bad parity, next frame follows immediately
      exp_s = CNT_EN ? ((k < 3) ? 2'(k) : 2'd3) : 2'd0;
      total++; if (dv_s !== 1'b1 || err_s !== 1'b1) $display("FAIL b2b_pulse_%0d: valid=%b err=%b expected 1 1", k, dv_s, err_s); else passed++;
      total++; if (cnt_s !== exp_s) $display("FAIL b2b_cnt_%0d: got %0d expected %0d", k, cnt_s, exp_s); else passed++;
      total++; if (cnt_e !== (CNT_EN ? 8'(k) : 8'd0)) $display("FAIL b2b_wide_cnt_%0d: got %0d expected %0d", k, cnt_e, CNT_EN ? k : 0); else passed++;
      $display("frame b2b %0d 110 p=1: err=%b cnt2=%0d cnt8=%0d", k, err_s, cnt_s, cnt_e);
    end
    gap(1, 1'b0);
    total++; if (cnt_s !== (CNT_EN ? 2'd3 : 2'd0)) $display("FAIL b2b_cnt_hold: got %0d expected %0d", cnt_s, CNT_EN ? 3 : 0); else passed++;
  endtask

  task automatic test_width1();
    send(1'b1, 1'b1);
    total++; if (dv_1 !== 1'b0 || busy_1 !== 1'b1) $display("FAIL w1_start: valid=%b busy=%b expected 0 1", dv_1, busy_1); else passed++;
    send(1'b1, 1'b0);
    total++; if (dv_1 !== 1'b1 || dout_1 !== 1'b1 || err_1 !== 1'b0) $display("FAIL w1_good: valid=%b data=%b err=%b expected 1 1 0", dv_1, dout_1, err_1); else passed++;
    $display("frame w1 1 p=1: data_out=%b err=%b", dout_1, err_1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    total++; if (dv_1 !== 1'b1 || dout_1 !== 1'b0 || err_1 !== 1'b1) $display("FAIL w1_bad: valid=%b data=%b err=%b expected 1 0 1", dv_1, dout_1, err_1); else passed++;
    $display("frame w1 0 p=1: data_out=%b err=%b", dout_1, err_1);
    gap(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_even_good();
    test_even_bad();
    test_ignored();
    test_gaps();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    test_width1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
